// File: rtl/tx_chksum_output_controller.sv
// -----------------------------------------------------------------------------
// tx_chksum_output_controller
//
// Purpose:
//   Downstream partner of the TX checksum input stage. Per-packet header
//   metadata (source/destination IP, payload length, TCP header) is held in a
//   small FIFO while the checksum engine works on the packet. Each checksum
//   the engine returns is paired with the oldest metadata entry. The checksum
//   is written into tcp_pkt_hdr.chksum and the completed header is presented
//   to the TX header assembler.
//
// Configuration macro:
//   TX_CHKSUM_OUT_REG_EN - when defined, the completed header is held in a
//                          single-entry output register, which adds one cycle
//                          of latency. When undefined, the join is purely
//                          combinational and adds no latency.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   src_meta_*                 metadata push interface (valid + payload)
//   meta_src_rdy               FIFO can accept a metadata entry
//   resp_csum/valid/ready      checksum response from the engine
//   chksum_dst_tx_*            completed header toward the assembler
//   dst_chksum_tx_hdr_rdy      assembler accepts the header
//   chksum_err_orphan_resp     sticky flag: a response arrived while the FIFO
//                              was empty
// -----------------------------------------------------------------------------
package tx_chksum_pkg;

    localparam int IP_ADDR_W = 32;
    localparam int TOT_LEN_W = 16;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [3:0]  rsvd;
        logic [7:0]  flags;
        logic [15:0] window;
        logic [15:0] chksum;
        logic [15:0] urg_ptr;
    } tcp_pkt_hdr;

    // One metadata FIFO entry. This is also the shape of the output header.
    typedef struct packed {
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
        logic [TOT_LEN_W-1:0] payload_len;
        tcp_pkt_hdr           tcp_hdr;
    } tx_meta_t;

endpackage

module tx_chksum_output_controller
    import tx_chksum_pkg::*;
#(
    parameter int META_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_meta_val,
    output logic                 meta_src_rdy,
    input  logic [IP_ADDR_W-1:0] src_meta_src_ip,
    input  logic [IP_ADDR_W-1:0] src_meta_dst_ip,
    input  logic [TOT_LEN_W-1:0] src_meta_payload_len,
    input  tcp_pkt_hdr           src_meta_tcp_hdr,
    input  logic [15:0]          resp_csum,
    input  logic                 resp_valid,
    output logic                 resp_ready,
    output logic                 chksum_dst_tx_hdr_val,
    input  logic                 dst_chksum_tx_hdr_rdy,
    output logic [IP_ADDR_W-1:0] chksum_dst_tx_src_ip,
    output logic [IP_ADDR_W-1:0] chksum_dst_tx_dst_ip,
    output logic [TOT_LEN_W-1:0] chksum_dst_tx_payload_len,
    output tcp_pkt_hdr           chksum_dst_tx_tcp_hdr,
    output logic                 chksum_err_orphan_resp
);

    localparam int META_PTR_W = $clog2(META_DEPTH);
    localparam logic [META_PTR_W:0] FULL_CNT = (META_PTR_W + 1)'(META_DEPTH);

    logic [META_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [META_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [META_PTR_W:0]   count_q, count_d;
    logic                  err_q, err_d;
    tx_meta_t              mem_q [META_DEPTH];

    logic     fifo_empty, fifo_full;
    logic     push, pop, sink_rdy, join_fire;
    tx_meta_t head, joined, out_meta;
    logic     out_val;

    // ---------------------------------------------------------------------
    // FIFO control and join
    // ---------------------------------------------------------------------
    // NOTE: every signal written in an always_comb block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == FULL_CNT);

        // A full FIFO refuses a push even if it pops in the same cycle.
        // This keeps ready off the pop path.
        meta_src_rdy = !rst && !fifo_full;
        push         = src_meta_val && meta_src_rdy;

        // Ready does not depend on resp_valid. It stays low while the FIFO
        // is empty, so an early response waits for its metadata.
        resp_ready   = !rst && !fifo_empty && sink_rdy;
        join_fire    = resp_valid && resp_ready;
        pop          = join_fire;

        head                  = mem_q[rd_ptr_q];
        joined                = head;
        joined.tcp_hdr.chksum = resp_csum;

        // Power-of-two depth: pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + META_PTR_W'(push);
        rd_ptr_d = rd_ptr_q + META_PTR_W'(pop);
        count_d  = count_q + (META_PTR_W + 1)'(push) - (META_PTR_W + 1)'(pop);

        err_d    = err_q || (resp_valid && fifo_empty);
    end

    // NOTE: synchronous reset, and all state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the storage array is not reset. The pointers and count decide
    // which entries are live, so stale contents are never observed.
    // A push writes storage this cycle, and the entry becomes visible at
    // the head only once count updates. There is no write-through.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{src_ip:      src_meta_src_ip,
                                 dst_ip:      src_meta_dst_ip,
                                 payload_len: src_meta_payload_len,
                                 tcp_hdr:     src_meta_tcp_hdr};
        end
    end

`ifdef TX_CHKSUM_OUT_REG_EN
    // ---------------------------------------------------------------------
    // Registered output: single-entry skid-free output buffer
    // ---------------------------------------------------------------------
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e out_state_q, out_state_d;
    tx_meta_t   out_q, out_d;

    // The register can take a new header when empty, or when the current
    // header leaves in this same cycle.
    assign sink_rdy = (out_state_q == OUT_EMPTY) || dst_chksum_tx_hdr_rdy;

    always_comb begin
        out_state_d = out_state_q;
        out_d       = out_q;
        if (join_fire) begin
            out_state_d = OUT_FULL;
            out_d       = joined;
        end else if (out_state_q == OUT_FULL && dst_chksum_tx_hdr_rdy) begin
            out_state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= OUT_EMPTY;
        end else begin
            out_state_q <= out_state_d;
        end
    end

    // The data register needs no reset. Outputs are zeroed while not valid.
    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    always_comb begin
        out_val  = !rst && (out_state_q == OUT_FULL);
        out_meta = out_val ? out_q : '0;
    end
`else
    // ---------------------------------------------------------------------
    // Combinational output: the header is valid in the same cycle the
    // response is presented.
    // ---------------------------------------------------------------------
    assign sink_rdy = dst_chksum_tx_hdr_rdy;

    always_comb begin
        out_val  = !rst && resp_valid && !fifo_empty;
        out_meta = out_val ? joined : '0;
    end
`endif

    assign chksum_dst_tx_hdr_val     = out_val;
    assign chksum_dst_tx_src_ip      = out_meta.src_ip;
    assign chksum_dst_tx_dst_ip      = out_meta.dst_ip;
    assign chksum_dst_tx_payload_len = out_meta.payload_len;
    assign chksum_dst_tx_tcp_hdr     = out_meta.tcp_hdr;
    assign chksum_err_orphan_resp    = err_q;

endmodule

// File: tb/tb_tx_chksum_output_controller.sv
// -----------------------------------------------------------------------------
// tb_tx_chksum_output_controller
//
// Self-checking bench for tx_chksum_output_controller.
//
// How expected headers are built:
//   - Metadata and checksums are logged into two model queues when issued.
//   - Entries are paired in order into an expected-header queue.
//
// How headers are checked:
//   - A monitor samples on the falling edge.
//   - It pops one expected header per downstream handshake (val & rdy).
//   - It also checks that outputs hold steady while the sink stalls.
// -----------------------------------------------------------------------------
module tb_tx_chksum_output_controller;
    import tx_chksum_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 src_meta_val;
    logic                 meta_src_rdy;
    logic [IP_ADDR_W-1:0] src_meta_src_ip;
    logic [IP_ADDR_W-1:0] src_meta_dst_ip;
    logic [TOT_LEN_W-1:0] src_meta_payload_len;
    tcp_pkt_hdr           src_meta_tcp_hdr;
    logic [15:0]          resp_csum;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 chksum_dst_tx_hdr_val;
    logic                 dst_chksum_tx_hdr_rdy;
    logic [IP_ADDR_W-1:0] chksum_dst_tx_src_ip;
    logic [IP_ADDR_W-1:0] chksum_dst_tx_dst_ip;
    logic [TOT_LEN_W-1:0] chksum_dst_tx_payload_len;
    tcp_pkt_hdr           chksum_dst_tx_tcp_hdr;
    logic                 chksum_err_orphan_resp;

    tx_chksum_output_controller #(.META_DEPTH(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .src_meta_val              (src_meta_val),
        .meta_src_rdy              (meta_src_rdy),
        .src_meta_src_ip           (src_meta_src_ip),
        .src_meta_dst_ip           (src_meta_dst_ip),
        .src_meta_payload_len      (src_meta_payload_len),
        .src_meta_tcp_hdr          (src_meta_tcp_hdr),
        .resp_csum                 (resp_csum),
        .resp_valid                (resp_valid),
        .resp_ready                (resp_ready),
        .chksum_dst_tx_hdr_val     (chksum_dst_tx_hdr_val),
        .dst_chksum_tx_hdr_rdy     (dst_chksum_tx_hdr_rdy),
        .chksum_dst_tx_src_ip      (chksum_dst_tx_src_ip),
        .chksum_dst_tx_dst_ip      (chksum_dst_tx_dst_ip),
        .chksum_dst_tx_payload_len (chksum_dst_tx_payload_len),
        .chksum_dst_tx_tcp_hdr     (chksum_dst_tx_tcp_hdr),
        .chksum_err_orphan_resp    (chksum_err_orphan_resp)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    tx_meta_t    meta_model_q[$];
    logic [15:0] csum_model_q[$];
    tx_meta_t    exp_q[$];
    tx_meta_t    dut_out;
    tx_meta_t    held;
    bit          held_v = 1'b0;
    bit          t4_done;

    assign dut_out = {chksum_dst_tx_src_ip, chksum_dst_tx_dst_ip,
                      chksum_dst_tx_payload_len, chksum_dst_tx_tcp_hdr};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tx_meta_t mk_meta(input logic [31:0] sip, input logic [31:0] dip,
                                         input logic [15:0] len, input logic [31:0] seq);
        tx_meta_t m;
        m.src_ip              = sip;
        m.dst_ip              = dip;
        m.payload_len         = len;
        m.tcp_hdr.src_port    = 16'h1F90;
        m.tcp_hdr.dst_port    = 16'h0050 + len;
        m.tcp_hdr.seq_num     = seq;
        m.tcp_hdr.ack_num     = ~seq;
        m.tcp_hdr.data_offset = 4'd5;
        m.tcp_hdr.rsvd        = 4'd0;
        m.tcp_hdr.flags       = 8'h18;
        m.tcp_hdr.window      = 16'hFFFF;
        m.tcp_hdr.chksum      = 16'hDEAD;  // don't-care; must be overwritten
        m.tcp_hdr.urg_ptr     = len ^ 16'h00FF;
        return m;
    endfunction

    // In-order join model: pair the oldest metadata with the oldest checksum.
    function automatic void pair_up();
        tx_meta_t m;
        while (meta_model_q.size() > 0 && csum_model_q.size() > 0) begin
            m                = meta_model_q.pop_front();
            m.tcp_hdr.chksum = csum_model_q.pop_front();
            exp_q.push_back(m);
        end
    endfunction

    // Callers start at posedge+1; tasks return at posedge+1 after acceptance.
    task automatic push_meta(input tx_meta_t m);
        bit done = 1'b0;
        meta_model_q.push_back(m);
        pair_up();
        src_meta_val         = 1'b1;
        src_meta_src_ip      = m.src_ip;
        src_meta_dst_ip      = m.dst_ip;
        src_meta_payload_len = m.payload_len;
        src_meta_tcp_hdr     = m.tcp_hdr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (meta_src_rdy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        src_meta_val = 1'b0;
        check("push_accept_within_budget", done, 1'b1);
    endtask

    task automatic send_resp(input logic [15:0] csum);
        bit done = 1'b0;
        csum_model_q.push_back(csum);
        pair_up();
        resp_valid = 1'b1;
        resp_csum  = csum;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (resp_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        resp_valid = 1'b0;
        check("resp_accept_within_budget", done, 1'b1);
    endtask

    // Monitor: scoreboard pop on handshake, stability check while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (held_v && !rst) begin
                check("stall_val_held", chksum_dst_tx_hdr_val, 1'b1);
                check("stall_data_held", dut_out, held);
            end
            held_v = 1'b0;
            if (!rst && chksum_dst_tx_hdr_val) begin
                if (!dst_chksum_tx_hdr_rdy) begin
                    held   = dut_out;
                    held_v = 1'b1;
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL hdr_unexpected: got %0h expected none", dut_out);
                end else begin
                    check("hdr_scoreboard", dut_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rdy_pat;
        tx_meta_t   m5;

        rdy_pat               = 4'b1001;  // sink pattern 1,0,0,1 (bit 0 first)
        rst                   = 1'b1;
        src_meta_val          = 1'b0;
        src_meta_src_ip       = '0;
        src_meta_dst_ip       = '0;
        src_meta_payload_len  = '0;
        src_meta_tcp_hdr      = '0;
        resp_csum             = '0;
        resp_valid            = 1'b0;
        dst_chksum_tx_hdr_rdy = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_meta_rdy_low", meta_src_rdy, 1'b0);
        check("rst_resp_ready_low", resp_ready, 1'b0);
        check("rst_hdr_val_low", chksum_dst_tx_hdr_val, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_meta_rdy", meta_src_rdy, 1'b1);
        check("post_rst_err", chksum_err_orphan_resp, 1'b0);
        check("post_rst_val", chksum_dst_tx_hdr_val, 1'b0);
        check("post_rst_data_zero", dut_out, '0);
        check("post_rst_count", dut.count_q, 0);
        @(posedge clk);
        #1;

        // ---------------- 1: single packet ----------------
        dst_chksum_tx_hdr_rdy = 1'b1;
        push_meta(mk_meta(32'h0A000001, 32'h0A000002, 16'd100, 32'h1234));
        csum_model_q.push_back(16'hBEEF);
        pair_up();
        resp_valid = 1'b1;
        resp_csum  = 16'hBEEF;
        @(negedge clk);
        check("t1_resp_ready", resp_ready, 1'b1);
`ifdef TX_CHKSUM_OUT_REG_EN
        check("t1_val_latency1_not_yet", chksum_dst_tx_hdr_val, 1'b0);
        @(posedge clk);
        #1 resp_valid = 1'b0;
        @(negedge clk);
        check("t1_val_latency1", chksum_dst_tx_hdr_val, 1'b1);
`else
        check("t1_val_latency0", chksum_dst_tx_hdr_val, 1'b1);
        @(posedge clk);
        #1 resp_valid = 1'b0;
`endif
        @(negedge clk);
        check("t1_count_zero", dut.count_q, 0);
        check("t1_err_clear", chksum_err_orphan_resp, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- 2 + 6: fill FIFO, held push, pop/push collision ----------------
        dst_chksum_tx_hdr_rdy = 1'b0;
        for (int i = 1; i <= 4; i++)
            push_meta(mk_meta(32'hC0A80000 + i, 32'hC0A80100 + i, 16'(i * 10), 32'h100 * i));
        m5 = mk_meta(32'hC0A80005, 32'hC0A80105, 16'd50, 32'h500);
        src_meta_val         = 1'b1;
        src_meta_src_ip      = m5.src_ip;
        src_meta_dst_ip      = m5.dst_ip;
        src_meta_payload_len = m5.payload_len;
        src_meta_tcp_hdr     = m5.tcp_hdr;
        @(negedge clk);
        check("t2_full_rdy_low", meta_src_rdy, 1'b0);
        check("t2_full_count", dut.count_q, 4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_fifth_held", dut.count_q, 4);
        @(posedge clk);
        #1;
        // Pop and push attempt in the same cycle while full.
        dst_chksum_tx_hdr_rdy = 1'b1;
        csum_model_q.push_back(16'h0001);
        pair_up();
        resp_valid = 1'b1;
        resp_csum  = 16'h0001;
        @(negedge clk);
        check("t6_push_refused_on_pop", meta_src_rdy, 1'b0);
        check("t6_pop_ready", resp_ready, 1'b1);
        @(posedge clk);
        #1;
        csum_model_q.push_back(16'h0002);
        pair_up();
        resp_csum = 16'h0002;
        @(negedge clk);
        check("t6_push_accepted_next", meta_src_rdy, 1'b1);
        @(posedge clk);
        #1;
        meta_model_q.push_back(m5);
        pair_up();
        src_meta_val = 1'b0;
        resp_valid   = 1'b0;
        send_resp(16'h0003);
        send_resp(16'h0004);
        send_resp(16'h0005);
        @(negedge clk);
        check("t2_drained", exp_q.size(), 0);
        check("t2_err_clear", chksum_err_orphan_resp, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- 3: orphan response ----------------
        fork
            send_resp(16'hAAAA);
            begin
                @(posedge clk);
                #1;
                push_meta(mk_meta(32'h08080808, 32'h01010101, 16'd64, 32'hCAFE0000));
            end
            begin
                @(negedge clk);
                check("t3_orphan_not_ready", resp_ready, 1'b0);
                check("t3_orphan_no_val", chksum_dst_tx_hdr_val, 1'b0);
                @(negedge clk);
                check("t3_err_set", chksum_err_orphan_resp, 1'b1);
                check("t3_no_write_through", resp_ready, 1'b0);
                @(negedge clk);
                check("t3_join_next_cycle", resp_ready, 1'b1);
`ifndef TX_CHKSUM_OUT_REG_EN
                check("t3_join_val", chksum_dst_tx_hdr_val, 1'b1);
`endif
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("t3_err_sticky", chksum_err_orphan_resp, 1'b1);

        // ---------------- 4: sink toggling 1,0,0,1, back-to-back responses ----------------
        t4_done = 1'b0;
        fork
            for (int i = 0; i < 8; i++)
                push_meta(mk_meta(32'hAC100000 + i, 32'hAC110000 + i, 16'(200 + i), 32'h4000 + i));
            begin
                for (int i = 0; i < 8; i++)
                    send_resp(16'h1000 + 16'(i));
                t4_done = 1'b1;
            end
            for (int c = 0; c < 1000 && !t4_done; c++) begin
                dst_chksum_tx_hdr_rdy = rdy_pat[c % 4];
                @(posedge clk);
                #1;
            end
        join
        dst_chksum_tx_hdr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_loss", exp_q.size(), 0);
        check("t4_err_sticky", chksum_err_orphan_resp, 1'b1);

        // ---------------- 5: reset with entries queued ----------------
        dst_chksum_tx_hdr_rdy = 1'b0;
        push_meta(mk_meta(32'h11111111, 32'h22222222, 16'd10, 32'h5001));
        push_meta(mk_meta(32'h33333333, 32'h44444444, 16'd20, 32'h5002));
        resp_valid = 1'b1;
        resp_csum  = 16'h5555;
        @(posedge clk);
        #1;
`ifdef TX_CHKSUM_OUT_REG_EN
        @(negedge clk);
        check("t5_out_full_before_rst", chksum_dst_tx_hdr_val, 1'b1);
        @(posedge clk);
        #1;
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        meta_model_q.delete();
        csum_model_q.delete();
        exp_q.delete();
        rst        = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        check("t5_val_low", chksum_dst_tx_hdr_val, 1'b0);
        check("t5_count_zero", dut.count_q, 0);
        check("t5_meta_rdy", meta_src_rdy, 1'b1);
        check("t5_err_cleared", chksum_err_orphan_resp, 1'b0);
        check("t5_resp_ready_low", resp_ready, 1'b0);
        @(posedge clk);
        #1;
        dst_chksum_tx_hdr_rdy = 1'b1;
        push_meta(mk_meta(32'h55555555, 32'h66666666, 16'd1500, 32'h77770000));
        send_resp(16'h7777);
        repeat (3) @(posedge clk);
        #1;
        check("t5_fresh_drained", exp_q.size(), 0);
        check("t5_err_still_clear", chksum_err_orphan_resp, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
